// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the mini-SRC control sequencer.
package cpu_ctrl_pkg;

   // Instruction opcodes (IR[31:27])
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU operation codes driven on opcode
   localparam logic [4:0] ALU_ADD = 5'b00011;
   localparam logic [4:0] ALU_AND = 5'b00101;
   localparam logic [4:0] ALU_OR  = 5'b00110;

   typedef enum logic [3:0] {
      StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
   } state_e;

   // Execute-phase behaviour groups
   typedef enum logic [3:0] {
      ClsRtype, ClsUnary, ClsImm, ClsLd, ClsSt, ClsBr, ClsSingle, ClsNone, ClsHalt
   } instr_cls_e;

   function automatic instr_cls_e decode_cls(input logic [4:0] op);
      instr_cls_e cls;
      if (op >= OP_ADD && op <= OP_SHL) begin
         cls = ClsRtype;
      end else begin
         case (op)
            OP_NEG, OP_NOT:                     cls = ClsUnary;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:   cls = ClsImm;
            OP_LD:                              cls = ClsLd;
            OP_ST:                              cls = ClsSt;
            OP_BR:                              cls = ClsBr;
            OP_JR, OP_MFHI, OP_MFLO, OP_IN,
            OP_OUT:                             cls = ClsSingle;
            OP_HALT:                            cls = ClsHalt;
            default:                            cls = ClsNone;
         endcase
      end
      return cls;
   endfunction

   // Final T-step of each group; StT2 means no execute steps at all
   function automatic state_e last_step(input instr_cls_e cls);
      state_e s;
      case (cls)
         ClsRtype, ClsImm: s = StT5;
         ClsUnary:         s = StT4;
         ClsLd, ClsSt:     s = StT7;
         ClsBr:            s = StT6;
         ClsSingle:        s = StT3;
         default:          s = StT2;
      endcase
      return s;
   endfunction

   function automatic logic [4:0] imm_alu(input logic [4:0] op);
      logic [4:0] alu;
      case (op)
         OP_ANDI: alu = ALU_AND;
         OP_ORI:  alu = ALU_OR;
         default: alu = ALU_ADD;
      endcase
      return alu;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Stretch counter for memory steps: done rises after MEM_WAIT extra cycles.
module mem_wait_counter (
   input  logic       Clock,
   input  logic       clr,
   input  logic       start,
   input  logic [2:0] MEM_WAIT,
   output logic       done
);

   logic [2:0] cnt_q, cnt_d;

   assign done = start && (cnt_q == MEM_WAIT);

   // Count while a memory step is active; clear on exit so the next entry starts at 0
   always_comb begin
      cnt_d = cnt_q;
      if (!start || done) cnt_d = 3'd0;
      else                cnt_d = cnt_q + 3'd1;
   end

   // Counter register, cleared asynchronously by clr
   always_ff @(posedge Clock or posedge clr) begin
      if (clr) cnt_q <= 3'd0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-step control sequencer for the mini-SRC datapath.
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic        Clock,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   output logic        PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out,
   output logic        MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
   output logic        HI_enable, LO_enable,
   output logic        IncPC, Read, RAM_write_enable, con_in, out_port_enable, in_port_enable,
   output logic        Gra, Grb, Grc, R_in, R_out, BA_out,
   output logic [4:0]  opcode,
   output logic        Run
);

   localparam logic [2:0] WaitCnt = 3'(MEM_WAIT);

   state_e     state_q;
   state_e     step_next;
   instr_cls_e cls;
   state_e     last;
   logic [4:0] op;
   logic       mem_step;
   logic       wait_done;
   logic       unused_ir;

   assign op        = IR[31:27];
   assign unused_ir = ^IR[26:0];
   assign cls       = decode_cls(op);
   assign last      = last_step(cls);
   assign mem_step  = (state_q == StT1) || (state_q == StT6 && cls == ClsLd) ||
                      (state_q == StT7 && cls == ClsSt);

   mem_wait_counter u_wait (
      .Clock    (Clock),
      .clr      (clr),
      .start    (mem_step),
      .MEM_WAIT (WaitCnt),
      .done     (wait_done)
   );

   // Sequential successor of each T-step
   always_comb begin
      step_next = StT0;
      case (state_q)
         StT0:    step_next = StT1;
         StT1:    step_next = StT2;
         StT2:    step_next = StT3;
         StT3:    step_next = StT4;
         StT4:    step_next = StT5;
         StT5:    step_next = StT6;
         StT6:    step_next = StT7;
         default: step_next = StT0;
      endcase
   end

   // State register; T2 already sees the new IR at its closing edge, so nop/halt exit there
   always_ff @(posedge Clock or posedge clr) begin
      if (clr) begin
         state_q <= StRst;
      end else begin
         case (state_q)
            StRst:  state_q <= StT0;
            StHalt: state_q <= StHalt;
            StT2: begin
               if (cls == ClsHalt)    state_q <= StHalt;
               else if (last == StT2) state_q <= StT0;
               else                   state_q <= StT3;
            end
            default: begin
               if (!mem_step || wait_done) begin
                  if (state_q == last) state_q <= StT0;
                  else                 state_q <= step_next;
               end
            end
         endcase
      end
   end

   // Control decode from state, opcode and CON_FF
   always_comb begin
      {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out} = '0;
      {MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable} = '0;
      {HI_enable, LO_enable} = '0;
      {IncPC, Read, RAM_write_enable, con_in, out_port_enable, in_port_enable} = '0;
      {Gra, Grb, Grc, R_in, R_out, BA_out} = '0;
      opcode = 5'b00000;
      Run    = (state_q != StRst) && (state_q != StHalt);
      case (state_q)
         StT0: begin
            PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1;
         end
         StT1: begin
            Read = 1'b1; MDR_enable = 1'b1;
         end
         StT2: begin
            MDR_out = 1'b1; IR_enable = 1'b1;
         end
         StT3: begin
            case (cls)
               ClsRtype: begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
               ClsUnary: begin Grb = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = op; end
               ClsImm, ClsLd, ClsSt: begin Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1; end
               ClsBr:    begin Gra = 1'b1; R_out = 1'b1; con_in = 1'b1; end
               ClsSingle: begin
                  case (op)
                     OP_JR:   begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                     OP_MFHI: begin HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                     OP_MFLO: begin LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                     OP_IN:   begin in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                     OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1; end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
         StT4: begin
            case (cls)
               ClsRtype: begin Grc = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = op; end
               ClsUnary: begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
               ClsImm, ClsLd, ClsSt: begin C_out = 1'b1; Z_enable = 1'b1; opcode = imm_alu(op); end
               ClsBr:    begin PC_out = 1'b1; Y_enable = 1'b1; end
               default: ;
            endcase
         end
         StT5: begin
            case (cls)
               ClsRtype, ClsImm: begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
               ClsLd, ClsSt:     begin ZLow_out = 1'b1; MAR_enable = 1'b1; end
               ClsBr:            begin C_out = 1'b1; Z_enable = 1'b1; opcode = ALU_ADD; end
               default: ;
            endcase
         end
         StT6: begin
            case (cls)
               ClsLd: begin Read = 1'b1; MDR_enable = 1'b1; end
               ClsSt: begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
               ClsBr: begin ZLow_out = 1'b1; PC_enable = CON_FF; end
               default: ;
            endcase
         end
         StT7: begin
            case (cls)
               ClsLd: begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
               ClsSt: RAM_write_enable = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomised scoreboard bench for control_unit.
module tb_control_unit;

   localparam int unsigned W = 2;

   // Bit positions in the packed observation word
   localparam int PC_O = 0, ZHI_O = 1, ZLO_O = 2, HI_O = 3, LO_O = 4, C_O = 5, MDR_O = 6;
   localparam int INP_O = 7, MAR_E = 8, MDR_E = 9, IR_E = 10, Y_E = 11, Z_E = 12, PC_E = 13;
   localparam int HI_E = 14, LO_E = 15, INC = 16, RD = 17, WR = 18, CONIN = 19, OUTP = 20;
   localparam int INP_E = 21, GRA = 22, GRB = 23, GRC = 24, RIN = 25, ROUT = 26, BAO = 27;
   localparam int RUN = 28;

   localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADDI = 5'b01100;
   localparam logic [4:0] ANDI = 5'b01101, ORI = 5'b01110, NEG = 5'b10001, NOTI = 5'b10010;
   localparam logic [4:0] BR = 5'b10011, JR = 5'b10100, IN = 5'b10110, OUT = 5'b10111;
   localparam logic [4:0] MFHI = 5'b11000, MFLO = 5'b11001, HALT = 5'b11011;

   logic        Clock = 1'b0;
   logic        clr, CON_FF;
   logic [31:0] IR;
   logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out;
   logic MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable;
   logic IncPC, Read, RAM_write_enable, con_in, out_port_enable, in_port_enable;
   logic Gra, Grb, Grc, R_in, R_out, BA_out, Run;
   logic [4:0] opcode;
   logic [33:0] obs;

   control_unit #(.MEM_WAIT(W)) dut (
      .Clock(Clock), .clr(clr), .IR(IR), .CON_FF(CON_FF),
      .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
      .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out),
      .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
      .Y_enable(Y_enable), .Z_enable(Z_enable), .PC_enable(PC_enable),
      .HI_enable(HI_enable), .LO_enable(LO_enable), .IncPC(IncPC), .Read(Read),
      .RAM_write_enable(RAM_write_enable), .con_in(con_in), .out_port_enable(out_port_enable),
      .in_port_enable(in_port_enable), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in),
      .R_out(R_out), .BA_out(BA_out), .opcode(opcode), .Run(Run)
   );

   always #5 Clock = ~Clock;

   always_comb begin
      obs = '0;
      obs[PC_O] = PC_out;   obs[ZHI_O] = ZHigh_out; obs[ZLO_O] = ZLow_out; obs[HI_O] = HI_out;
      obs[LO_O] = LO_out;   obs[C_O] = C_out;       obs[MDR_O] = MDR_out;  obs[INP_O] = in_port_out;
      obs[MAR_E] = MAR_enable; obs[MDR_E] = MDR_enable; obs[IR_E] = IR_enable;
      obs[Y_E] = Y_enable;  obs[Z_E] = Z_enable;    obs[PC_E] = PC_enable; obs[HI_E] = HI_enable;
      obs[LO_E] = LO_enable; obs[INC] = IncPC;      obs[RD] = Read;        obs[WR] = RAM_write_enable;
      obs[CONIN] = con_in;  obs[OUTP] = out_port_enable; obs[INP_E] = in_port_enable;
      obs[GRA] = Gra; obs[GRB] = Grb; obs[GRC] = Grc; obs[RIN] = R_in; obs[ROUT] = R_out;
      obs[BAO] = BA_out; obs[RUN] = Run; obs[33:29] = opcode;
   end

   typedef struct { logic [33:0] cw; string tag; } exp_t;
   typedef struct { logic [33:0] cw; bit mem; bit csamp; string tag; } step_t;

   exp_t  sb[$];
   step_t steps[$];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic logic [33:0] b(input int i);
      logic [33:0] one;
      one = 34'd1;
      return one << i;
   endfunction

   function automatic logic [33:0] opc(input logic [4:0] o);
      return {o, 29'd0};
   endfunction

   task automatic add_step(input logic [33:0] cw, input bit mem, input bit cs, input string tag);
      step_t s;
      s.cw = cw | b(RUN); s.mem = mem; s.csamp = cs; s.tag = tag;
      steps.push_back(s);
   endtask

   // One cycle of stimulus: drive inputs just after the edge and queue what that cycle must show
   task automatic slot(input logic [33:0] cw, input string tag, input logic c,
                       input logic [31:0] ir, input logic con);
      exp_t e;
      @(posedge Clock);
      #1;
      clr = c; IR = ir; CON_FF = con;
      e.cw = cw; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, req, $time);
      end
   endtask

   // Step list straight from the instruction table
   task automatic build(input logic [4:0] op, input logic con);
      logic [4:0] alu;
      steps.delete();
      add_step(b(PC_O) | b(MAR_E) | b(INC) | b(PC_E), 0, 0, "T0");
      add_step(b(RD) | b(MDR_E), 1, 0, "T1");
      add_step(b(MDR_O) | b(IR_E), 0, 0, "T2");
      alu = (op == ANDI) ? 5'b00101 : (op == ORI) ? 5'b00110 : 5'b00011;
      if (op >= 5'b00011 && op <= 5'b01011) begin
         add_step(b(GRB) | b(ROUT) | b(Y_E), 0, 0, "R T3");
         add_step(b(GRC) | b(ROUT) | b(Z_E) | opc(op), 0, 0, "R T4");
         add_step(b(ZLO_O) | b(GRA) | b(RIN), 0, 0, "R T5");
      end else if (op == NEG || op == NOTI) begin
         add_step(b(GRB) | b(ROUT) | b(Z_E) | opc(op), 0, 0, "neg/not T3");
         add_step(b(ZLO_O) | b(GRA) | b(RIN), 0, 0, "neg/not T4");
      end else if (op == ADDI || op == ANDI || op == ORI || op == LDI || op == LD || op == ST) begin
         add_step(b(GRB) | b(BAO) | b(Y_E), 0, 0, "imm T3");
         add_step(b(C_O) | b(Z_E) | opc(alu), 0, 0, "imm T4");
         if (op == LD || op == ST) begin
            add_step(b(ZLO_O) | b(MAR_E), 0, 0, "ldst T5");
            if (op == LD) begin
               add_step(b(RD) | b(MDR_E), 1, 0, "ld T6");
               add_step(b(MDR_O) | b(GRA) | b(RIN), 0, 0, "ld T7");
            end else begin
               add_step(b(GRA) | b(ROUT) | b(MDR_E), 0, 0, "st T6");
               add_step(b(WR), 1, 0, "st T7");
            end
         end else begin
            add_step(b(ZLO_O) | b(GRA) | b(RIN), 0, 0, "imm T5");
         end
      end else if (op == BR) begin
         add_step(b(GRA) | b(ROUT) | b(CONIN), 0, 0, "br T3");
         add_step(b(PC_O) | b(Y_E), 0, 0, "br T4");
         add_step(b(C_O) | b(Z_E) | opc(5'b00011), 0, 0, "br T5");
         add_step(b(ZLO_O) | (con ? b(PC_E) : 34'd0), 0, 1, "br T6");
      end else if (op == JR)   add_step(b(GRA) | b(ROUT) | b(PC_E), 0, 0, "jr T3");
      else if (op == MFHI) add_step(b(HI_O) | b(GRA) | b(RIN), 0, 0, "mfhi T3");
      else if (op == MFLO) add_step(b(LO_O) | b(GRA) | b(RIN), 0, 0, "mflo T3");
      else if (op == IN)   add_step(b(INP_O) | b(GRA) | b(RIN), 0, 0, "in T3");
      else if (op == OUT)  add_step(b(GRA) | b(ROUT) | b(OUTP), 0, 0, "out T3");
   endtask

   task automatic run_instr(input logic [4:0] op, input logic con, input bit mid_reset);
      logic [31:0] r, ir, irv;
      logic        cv;
      int          reps;
      r  = $urandom();
      ir = {op, r[26:0]};
      build(op, con);
      for (int i = 0; i < steps.size(); i++) begin
         reps = steps[i].mem ? int'(W) + 1 : 1;
         for (int k = 0; k < reps; k++) begin
            // IR only matters from T2's closing edge on; feed junk during T0/T1
            irv = (i < 2) ? $urandom() : ir;
            cv  = steps[i].csamp ? con : 1'($urandom());
            if (mid_reset && i == steps.size() - 1) begin
               @(posedge Clock);
               #1;
               IR = irv; CON_FF = cv;
               chk("st T7 write before clr", RAM_write_enable, 1'b1);
               #1;
               clr = 1'b1;
               #1;
               chk("st T7 write after async clr", RAM_write_enable, 1'b0);
               chk("st T7 Run after async clr", Run, 1'b0);
               sb.push_back('{cw: 34'd0, tag: "st clr cycle"});
               slot(34'd0, "clr held", 1'b1, ir, 1'b0);
               slot(34'd0, "clr release", 1'b0, ir, 1'b0);
               return;
            end
            slot(steps[i].cw, steps[i].tag, 1'b0, irv, cv);
         end
      end
      if (op == HALT) begin
         repeat (20) slot(34'd0, "HALT", 1'b0, ir, 1'($urandom()));
         slot(34'd0, "halt clr", 1'b1, ir, 1'b0);
         slot(34'd0, "halt clr release", 1'b0, ir, 1'b0);
      end
   endtask

   task automatic run_random(input int n);
      logic [4:0] op;
      for (int i = 0; i < n; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == HALT) op = 5'b11010;
         run_instr(op, 1'($urandom()), 1'b0);
      end
   endtask

   // Monitor: every cycle the DUT presents a control word, check it against the queue
   always @(negedge Clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e.cw) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", e.tag, obs, e.cw, $time);
         end
      end
   end

   initial begin
      clr = 1'b1; IR = 32'd0; CON_FF = 1'b0;
      slot(34'd0, "reset", 1'b1, 32'd0, 1'b0);
      slot(34'd0, "reset", 1'b1, 32'd0, 1'b0);
      slot(34'd0, "reset release", 1'b0, 32'd0, 1'b0);
      run_instr(ADDI, 1'b0, 1'b0);
      run_instr(LD, 1'b0, 1'b0);
      run_instr(ST, 1'b0, 1'b0);
      run_instr(BR, 1'b0, 1'b0);
      run_instr(BR, 1'b1, 1'b0);
      run_random(60);
      run_instr(HALT, 1'b0, 1'b0);
      run_random(10);
      run_instr(ST, 1'b0, 1'b1);
      run_random(10);
      @(posedge Clock);
      @(negedge Clock);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
